// File: rtl/pgm_pkg.sv
// pgm_sequencer shared definitions.
// FSM state encodings and opcode constants.
package pgm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_JNP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

endpackage

// File: rtl/pgm_decode.sv
// pgm_sequencer instruction decode.
// Pure function of IR and R; the top gates the strobes with EXEC.
module pgm_decode
    import pgm_pkg::*;
#(
    parameter int DW = 4,
    parameter int IW = 4
) (
    input  logic [IW-1:0] ir,
    input  logic [DW-1:0] r,
    output logic          inc,
    output logic          jnp,
    output logic          i1,
    output logic          i0,
    output logic [DW-1:0] r_next,
    output logic          go_halt
);

    always_comb begin
        inc     = 1'b0;
        jnp     = 1'b0;
        i1      = 1'b0;
        i0      = 1'b0;
        r_next  = r;
        go_halt = 1'b0;
        unique case (ir[3:2])
            OP_INC: begin
                inc    = 1'b1;
                r_next = r + 1'b1;
            end
            OP_DEC: begin
                inc    = 1'b1;
                // saturate: R=0 stays 0
                r_next = (r == '0) ? r : r - 1'b1;
            end
            OP_JNP: begin
                jnp = 1'b1;
                i1  = ir[1];
                i0  = ir[0];
            end
            OP_HALT: go_halt = 1'b1;
        endcase
    end

endmodule

// File: rtl/pgm_sequencer.sv
// Control sequencer paired with programCounter.
// Fetches over req/ack, executes one cycle per instruction.
module pgm_sequencer
    import pgm_pkg::*;
#(
    parameter int DW = 4,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          p1,
    input  logic          p0,
    output logic          imem_req,
    output logic [1:0]    imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic          jnp,
    output logic          inc,
    output logic          i1,
    output logic          i0,
    output logic          r2,
    output logic [DW-1:0] r_out,
    output logic          halted
);

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] ir_q;
    logic [DW-1:0] r_q;
    logic [DW-1:0] r_next;
    logic          d_inc;
    logic          d_jnp;
    logic          d_i1;
    logic          d_i0;
    logic          d_halt;

    pgm_decode #(
        .DW (DW),
        .IW (IW)
    ) u_decode (
        .ir      (ir_q),
        .r       (r_q),
        .inc     (d_inc),
        .jnp     (d_jnp),
        .i1      (d_i1),
        .i0      (d_i0),
        .r_next  (r_next),
        .go_halt (d_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && imem_ack)
                ir_q <= imem_data;
            if (state_q == EXEC)
                r_q <= r_next;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        inc      = 1'b0;
        jnp      = 1'b0;
        i1       = 1'b0;
        i0       = 1'b0;
        halted   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run)
                    state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_d = EXEC;
            end
            EXEC: begin
                inc     = d_inc;
                jnp     = d_jnp;
                i1      = d_i1;
                i0      = d_i0;
                state_d = d_halt ? HALT : FETCH;
            end
            HALT: halted = 1'b1;
        endcase
    end

    // r2 reflects registered R, so it is the pre-update flag during EXEC
    assign r2        = |r_q;
    assign r_out     = r_q;
    assign imem_addr = {p1, p0};

endmodule
